xor_stream_checker: RTL and testbench
=====================================

# xor_stream_checker

Downstream consumer for the two-input XOR stage. It samples that stage's combinational output and its registered output together. Within a framed run it checks that the registered bit equals the combinational bit from the previous accepted sample, and counts mismatches. It also packs the registered stream into bytes for a host or log sink.

## Interface
- FRAME_LEN, 10: accepted samples per frame, including the arming sample; legal range 2–255.
- CNT_W, 8: width of the mismatch counter.

- clk  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-low.
- start  in  1  single-cycle frame start; honoured only in IDLE.
- in_valid  in  1  sample strobe; bit_comb/bit_ff are accepted on a clk edge where this is high.
- bit_comb  in  1  combinational XOR output of the upstream stage.
- bit_ff  in  1  registered XOR output of the upstream stage.
- busy  out  1  high in ARM and RUN.
- word_out  out  8  packed bit_ff bits, first-received bit in the MSB.
- word_valid  out  1  one-cycle strobe qualifying word_out.
- err  out  1  mismatch indication; see Configuration.
- err_cnt  out  CNT_W  mismatches in the current or last frame; saturates at all-ones.
- done  out  1  one-cycle strobe marking the end of a frame.

## Operation
- FSM states: IDLE, ARM, RUN, DONE.
- IDLE → ARM on start.
- ARM → RUN on the first accepted sample.
- RUN → DONE on the accepted sample that completes FRAME_LEN samples.
- DONE → IDLE unconditionally after one cycle.
- On the start edge: err_cnt, err, the sample counter, the shift register and the bit count are all cleared.
- ARM sample:
  - Captures bit_comb into prev_comb.
  - No comparison is made and nothing is shifted, because the registered path has no predecessor yet.
- RUN sample:
  - Compare bit_ff with prev_comb. On inequality, increment err_cnt, saturating at all-ones.
  - Load prev_comb with bit_comb.
  - Shift: sr = {sr[6:0], bit_ff}; increment the bit count.
- Word output:
  - When the bit count reaches 8, word_out = sr and word_valid pulses; the bit count returns to 0.
  - On the final RUN sample, if the bit count is nonzero after the shift, the partial word is flushed. The received bits are right-aligned and the upper bits are zero.
- in_valid low in ARM or RUN: all state is held; there is no timeout.
- start is ignored outside IDLE.
- in_valid outside ARM/RUN is ignored.
- Reset at any time, including mid-frame:
  - The FSM returns to IDLE and any partial word is discarded.
  - All outputs go to 0: busy, word_out, word_valid, err, err_cnt, done.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- word_valid, word_out, and err_cnt/err updates become visible in the cycle after the clk edge that accepted the sample.
- done and any flush word_valid are asserted together, in the cycle after the final sample edge, which is the DONE cycle.
- busy rises in the cycle after start and falls in the DONE cycle.
- Minimum frame duration is FRAME_LEN+2 cycles: one edge for start, FRAME_LEN samples, one DONE cycle.
- A start in the DONE cycle is ignored.
- A start in the cycle after DONE is accepted.

## Configuration
- STICKY_ERR_EN:
  - Defined: err goes high on the first mismatch and stays high until the next accepted start or reset.
  - Undefined: err is a one-cycle pulse per mismatching sample, aligned with the err_cnt increment.
- err_cnt behaviour is identical in both builds.

## Test plan
- Clean frame, FRAME_LEN=10:
  - Stimulus: start, then 10 consecutive samples with bit_comb = 0,1,1,0,0,1,1,0,0,1 and bit_ff = 0,0,1,1,0,0,1,1,0,0.
  - Response: word_valid with word_out=0x66 after sample 9; flush word_out=0x00 together with done after sample 10; err_cnt=0; err never high.
- Single mismatch:
  - Stimulus: same stream, with bit_ff of sample 5 forced to 1.
  - Response: err_cnt=1; first word_out=0x76.
  - STICKY_ERR_EN defined: err stays high through done.
  - STICKY_ERR_EN undefined: err pulses exactly once.
- Gapped valid:
  - Stimulus: the clean stream with in_valid low for 3 cycles between samples 4 and 5.
  - Response: identical outputs to the clean frame; done is 3 cycles later.
- Reset mid-frame:
  - Stimulus: reset low for 1 cycle after sample 6, then a new clean frame.
  - Response: no word_valid and no done from the aborted frame; all outputs 0 the cycle after reset; the new frame gives the clean-frame results.
- Saturation, CNT_W=2:
  - Stimulus: 9 RUN samples, all mismatching.
  - Response: err_cnt holds at 3; no wrap.
- Start handling:
  - Stimulus: start held high through an entire frame and into the DONE cycle; then a start one cycle after DONE.
  - Response: only one frame is run and counters are not cleared mid-frame; the later start begins a new frame.

Source files
------------

// File: rtl/xor_stream_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : xor_stream_checker_if
// Description : Sample/result bundle between an XOR-stage consumer and its
//               environment. The master side drives the frame start and the
//               sampled XOR bits. The slave side (the checker) returns the
//               frame status, the packed words and the mismatch results.
//               Signals:
//                 start, in_valid, bit_comb, bit_ff      master -> slave
//                 busy, word_out[7:0], word_valid,
//                 err, err_cnt[CNT_W-1:0], done          slave -> master
// Revision    : 1.0  initial release
// ============================================================================
interface xor_stream_checker_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             in_valid;
    logic             bit_comb;
    logic             bit_ff;
    logic             busy;
    logic [7:0]       word_out;
    logic             word_valid;
    logic             err;
    logic [CNT_W-1:0] err_cnt;
    logic             done;

    modport master (
        output start, in_valid, bit_comb, bit_ff,
        input  busy, word_out, word_valid, err, err_cnt, done
    );

    modport slave (
        input  start, in_valid, bit_comb, bit_ff,
        output busy, word_out, word_valid, err, err_cnt, done
    );
endinterface
`default_nettype wire

// File: rtl/xor_stream_checker.sv
`default_nettype none
// ============================================================================
// Module      : xor_stream_checker
// Description : Consumer for a two-input XOR stage. Within a frame of
//               FRAME_LEN accepted samples, it checks that each registered
//               bit equals the combinational bit of the previous accepted
//               sample. It counts mismatches (saturating) and packs the
//               registered bits into bytes, MSB first. The final partial
//               byte is flushed right-aligned together with done.
// Ports       : clk    rising-edge clock
//               reset  synchronous, active-low reset
//               bus    xor_stream_checker_if.slave. The inputs are start,
//                      in_valid, bit_comb and bit_ff. The outputs are busy,
//                      word_out, word_valid, err, err_cnt and done, and all
//                      of them are registered.
// Parameters  : FRAME_LEN  accepted samples per frame incl. arming (2..255)
//               CNT_W      mismatch counter width
// Macro       : STICKY_ERR_EN - when defined, err stays high from the first
//               mismatch until the next accepted start or reset. Otherwise
//               err pulses for one cycle per mismatching sample.
// Revision    : 1.0  initial release
// ============================================================================
module xor_stream_checker #(
    parameter int FRAME_LEN = 10,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    xor_stream_checker_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Index of the final sample: counter holds samples already accepted.
    localparam logic [7:0]       c_LAST_IDX = 8'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_next;

    logic             r_prev_comb;
    logic [7:0]       r_sample_cnt;
    logic [7:0]       r_sr;
    logic [2:0]       r_bit_cnt;

    logic             r_busy;
    logic [7:0]       r_word_out;
    logic             r_word_valid;
    logic             r_err;
    logic [CNT_W-1:0] r_err_cnt;
    logic             r_done;

    logic             w_start_ok;
    logic             w_run_acc;
    logic             w_last;
    logic             w_mismatch;
    logic [7:0]       w_sr_shift;
    logic             w_word_full;

    assign w_start_ok  = (r_state == S_IDLE) && bus.start;
    assign w_run_acc   = (r_state == S_RUN) && bus.in_valid;
    assign w_last      = w_run_acc && (r_sample_cnt == c_LAST_IDX);
    assign w_mismatch  = w_run_acc && (bus.bit_ff != r_prev_comb);
    assign w_sr_shift  = {r_sr[6:0], bus.bit_ff};
    // Seven bits already held: this shift completes a byte.
    assign w_word_full = (r_bit_cnt == 3'd7);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start)    w_state_next = S_ARM;
            S_ARM:   if (bus.in_valid) w_state_next = S_RUN;
            S_RUN:   if (w_last)       w_state_next = S_DONE;
            S_DONE:                    w_state_next = S_IDLE;
            default:                   w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prev_comb  <= 1'b0;
            r_sample_cnt <= 8'd0;
            r_sr         <= 8'd0;
            r_bit_cnt    <= 3'd0;
            r_busy       <= 1'b0;
            r_word_out   <= 8'd0;
            r_word_valid <= 1'b0;
            r_err        <= 1'b0;
            r_err_cnt    <= '0;
            r_done       <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            r_done       <= w_last;
            // Registering the next-state decode makes busy rise the cycle
            // after start and fall in the DONE cycle.
            r_busy       <= (w_state_next == S_ARM) || (w_state_next == S_RUN);

`ifdef STICKY_ERR_EN
            if (w_start_ok) begin
                r_err <= 1'b0;
            end else if (w_mismatch) begin
                r_err <= 1'b1;
            end
`else
            r_err <= w_mismatch;
`endif

            if (w_start_ok) begin
                r_err_cnt    <= '0;
                r_sample_cnt <= 8'd0;
                r_sr         <= 8'd0;
                r_bit_cnt    <= 3'd0;
            end

            // The arming sample only seeds the predecessor bit.
            if ((r_state == S_ARM) && bus.in_valid) begin
                r_prev_comb  <= bus.bit_comb;
                r_sample_cnt <= 8'd1;
            end

            if (w_run_acc) begin
                r_prev_comb  <= bus.bit_comb;
                r_sample_cnt <= r_sample_cnt + 8'd1;

                if (w_mismatch && (r_err_cnt != '1)) begin
                    r_err_cnt <= r_err_cnt + c_CNT_ONE;
                end

                if (w_word_full) begin
                    // The shift register is cleared after each full byte, so a
                    // later partial flush is right-aligned with zero upper bits.
                    r_word_out   <= w_sr_shift;
                    r_word_valid <= 1'b1;
                    r_sr         <= 8'd0;
                    r_bit_cnt    <= 3'd0;
                end else begin
                    r_sr      <= w_sr_shift;
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (w_last) begin
                        r_word_out   <= w_sr_shift;
                        r_word_valid <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.busy       = r_busy;
    assign bus.word_out   = r_word_out;
    assign bus.word_valid = r_word_valid;
    assign bus.err        = r_err;
    assign bus.err_cnt    = r_err_cnt;
    assign bus.done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_xor_stream_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_xor_stream_checker
// Description : Self-checking bench for xor_stream_checker. Two instances
//               (CNT_W=8 and CNT_W=2) receive identical stimulus. After every
//               clock edge, a snapshot of all outputs from both instances is
//               compared with a frame-level reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_xor_stream_checker;

    localparam int N = 10;
`ifdef STICKY_ERR_EN
    localparam bit c_STICKY = 1'b1;
`else
    localparam bit c_STICKY = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic t_reset, t_start, t_valid, t_comb, t_ff;

    xor_stream_checker_if #(.CNT_W(8)) bus1 ();
    xor_stream_checker_if #(.CNT_W(2)) bus2 ();

    assign bus1.start    = t_start;
    assign bus1.in_valid = t_valid;
    assign bus1.bit_comb = t_comb;
    assign bus1.bit_ff   = t_ff;
    assign bus2.start    = t_start;
    assign bus2.in_valid = t_valid;
    assign bus2.bit_comb = t_comb;
    assign bus2.bit_ff   = t_ff;

    xor_stream_checker #(.FRAME_LEN(N), .CNT_W(8)) u_dut8 (
        .clk   (clk),
        .reset (t_reset),
        .bus   (bus1)
    );

    xor_stream_checker #(.FRAME_LEN(N), .CNT_W(2)) u_dut2 (
        .clk   (clk),
        .reset (t_reset),
        .bus   (bus2)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Frame stimulus and reference model state
    bit   s_comb [N];
    bit   s_ff   [N];
    int   s_gap  [N];
    bit   e_busy, e_wv, e_done, e_err;
    int   e_cnt;
    logic [7:0] e_word;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Observed outputs of both instances; word_out only counts when qualified.
    function automatic logic [33:0] snap();
        return {bus1.busy, bus1.word_valid, bus1.done, bus1.err, bus1.err_cnt,
                (bus1.word_valid ? bus1.word_out : 8'h00),
                bus2.busy, bus2.word_valid, bus2.done, bus2.err, bus2.err_cnt,
                (bus2.word_valid ? bus2.word_out : 8'h00)};
    endfunction

    function automatic logic [33:0] expv();
        logic [7:0] c8;
        logic [1:0] c2;
        logic [7:0] w;
        c8 = (e_cnt > 255) ? 8'hFF : 8'(e_cnt);
        c2 = (e_cnt > 3)   ? 2'd3  : 2'(e_cnt);
        w  = e_wv ? e_word : 8'h00;
        return {e_busy, e_wv, e_done, e_err, c8, w,
                e_busy, e_wv, e_done, e_err, c2, w};
    endfunction

    // Bits lo..hi of the registered stream, first bit toward the MSB.
    function automatic logic [7:0] pack(int lo, int hi);
        logic [7:0] w;
        w = 8'h00;
        for (int j = lo; j <= hi; j++) w = {w[6:0], s_ff[j]};
        return w;
    endfunction

    task automatic set_clean();
        logic [0:N-1] vc;
        logic [0:N-1] vf;
        vc = 10'b0110011001;
        vf = 10'b0011001100;
        for (int i = 0; i < N; i++) begin
            s_comb[i] = vc[i];
            s_ff[i]   = vf[i];
            s_gap[i]  = 0;
        end
    endtask

    // Runs one frame. abort_idx >= 0 pulses reset after that sample.
    // hold_start keeps start high through the frame and its DONE cycle.
    task automatic run_frame(input int abort_idx, input bit hold_start,
                             output int done_cycle);
        int  cycles;
        bit  m;
        cycles     = 0;
        done_cycle = -1;
        t_start = 1'b1; t_valid = 1'b0;
        cyc();
        e_busy = 1'b1; e_wv = 1'b0; e_done = 1'b0; e_err = 1'b0; e_cnt = 0;
        n_checks++;
        if (snap() !== expv()) $display("FAIL start_edge: got %h expected %h", snap(), expv());
        else n_pass++;
        if (!hold_start) t_start = 1'b0;

        for (int k = 0; k < N; k++) begin
            for (int g = 0; g < s_gap[k]; g++) begin
                t_valid = 1'b0; t_comb = 1'($urandom); t_ff = 1'($urandom);
                cyc(); cycles++;
                e_wv = 1'b0; e_done = 1'b0;
                if (!c_STICKY) e_err = 1'b0;
                n_checks++;
                if (snap() !== expv()) $display("FAIL gap_before_%0d: got %h expected %h", k, snap(), expv());
                else n_pass++;
            end
            t_valid = 1'b1; t_comb = s_comb[k]; t_ff = s_ff[k];
            cyc(); cycles++;
            e_wv = 1'b0; e_done = 1'b0;
            if (!c_STICKY) e_err = 1'b0;
            if (k > 0) begin
                m = (s_ff[k] != s_comb[k-1]);
                if (m) begin
                    e_cnt++;
                    e_err = 1'b1;
                end
                if (k % 8 == 0) begin
                    e_wv = 1'b1; e_word = pack(k - 7, k);
                end else if (k == N - 1) begin
                    e_wv = 1'b1; e_word = pack(k - (k % 8) + 1, k);
                end
            end
            if (k == N - 1) begin
                e_done = 1'b1; e_busy = 1'b0; done_cycle = cycles;
            end
            n_checks++;
            if (snap() !== expv()) $display("FAIL sample_%0d: got %h expected %h", k, snap(), expv());
            else n_pass++;

            if (k == abort_idx) begin
                t_valid = 1'b0; t_reset = 1'b0;
                cyc();
                e_busy = 1'b0; e_wv = 1'b0; e_done = 1'b0; e_err = 1'b0; e_cnt = 0;
                n_checks++;
                if (snap() !== expv()) $display("FAIL abort_reset: got %h expected %h", snap(), expv());
                else n_pass++;
                t_reset = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    t_valid = 1'b1; t_comb = 1'($urandom); t_ff = 1'($urandom);
                    cyc();
                    n_checks++;
                    if (snap() !== expv()) $display("FAIL after_abort_%0d: got %h expected %h", i, snap(), expv());
                    else n_pass++;
                end
                t_valid = 1'b0;
                return;
            end
        end

        // DONE -> IDLE edge (start may still be high and must be ignored)
        t_valid = 1'b0;
        cyc();
        e_busy = 1'b0; e_wv = 1'b0; e_done = 1'b0;
        if (!c_STICKY) e_err = 1'b0;
        n_checks++;
        if (snap() !== expv()) $display("FAIL post_done: got %h expected %h", snap(), expv());
        else n_pass++;
        t_start = 1'b0;
    endtask

    task automatic test_reset();
        t_reset = 1'b0; t_start = 1'b0; t_valid = 1'b0; t_comb = 1'b0; t_ff = 1'b0;
        e_busy = 1'b0; e_wv = 1'b0; e_done = 1'b0; e_err = 1'b0; e_cnt = 0; e_word = 8'h00;
        for (int i = 0; i < 3; i++) begin
            t_start = 1'($urandom); t_valid = 1'($urandom);
            t_comb = 1'($urandom); t_ff = 1'($urandom);
            cyc();
            n_checks++;
            if (snap() !== expv()) $display("FAIL reset_state_%0d: got %h expected %h", i, snap(), expv());
            else n_pass++;
        end
        t_reset = 1'b1; t_start = 1'b0; t_valid = 1'b0;
        cyc();
        n_checks++;
        if (snap() !== expv()) $display("FAIL reset_release: got %h expected %h", snap(), expv());
        else n_pass++;
    endtask

    task automatic test_clean();
        int dc;
        set_clean();
        run_frame(-1, 1'b0, dc);
        n_checks++;
        if (dc !== N) $display("FAIL clean_done_cycle: got %0d expected %0d", dc, N);
        else n_pass++;
    endtask

    task automatic test_mismatch();
        int dc;
        set_clean();
        s_ff[4] = 1'b1;
        run_frame(-1, 1'b0, dc);
    endtask

    task automatic test_gapped();
        int dc;
        set_clean();
        s_gap[4] = 3;
        run_frame(-1, 1'b0, dc);
        n_checks++;
        if (dc !== N + 3) $display("FAIL gapped_done_cycle: got %0d expected %0d", dc, N + 3);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int dc;
        set_clean();
        run_frame(5, 1'b0, dc);
        set_clean();
        run_frame(-1, 1'b0, dc);
    endtask

    task automatic test_saturation();
        int dc;
        for (int i = 0; i < N; i++) begin
            s_comb[i] = 1'($urandom);
            s_gap[i]  = 0;
        end
        s_ff[0] = 1'($urandom);
        for (int i = 1; i < N; i++) s_ff[i] = ~s_comb[i-1];
        run_frame(-1, 1'b0, dc);
    endtask

    task automatic test_start_hold();
        int dc;
        set_clean();
        s_ff[2] = ~s_ff[2];
        s_ff[7] = ~s_ff[7];
        run_frame(-1, 1'b1, dc);
        // Start in the cycle right after DONE must open a new frame.
        set_clean();
        run_frame(-1, 1'b0, dc);
    endtask

    task automatic test_idle_ignore();
        for (int i = 0; i < 4; i++) begin
            t_valid = 1'b1; t_comb = 1'($urandom); t_ff = 1'($urandom);
            cyc();
            e_busy = 1'b0; e_wv = 1'b0; e_done = 1'b0;
            if (!c_STICKY) e_err = 1'b0;
            n_checks++;
            if (snap() !== expv()) $display("FAIL idle_ignore_%0d: got %h expected %h", i, snap(), expv());
            else n_pass++;
        end
        t_valid = 1'b0;
    endtask

    task automatic test_random();
        int dc;
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < N; i++) begin
                s_comb[i] = 1'($urandom);
                s_gap[i]  = int'($urandom_range(0, 2));
            end
            s_ff[0] = 1'($urandom);
            for (int i = 1; i < N; i++)
                s_ff[i] = s_comb[i-1] ^ ($urandom_range(0, 3) == 0);
            run_frame(-1, 1'b0, dc);
            test_idle_ignore();
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_mismatch();
        test_idle_ignore();
        test_gapped();
        test_reset_mid();
        test_saturation();
        test_start_hold();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
